// File: rtl/toy_bus_rsp_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module      : toy_bus_rsp_arb_2to1
// Description : Round-robin merge of two target response channels into one
//               registered response channel toward the LSU initiator.
// Revision    : 1.0 - initial release
// ============================================================================
module toy_bus_rsp_arb_2to1 #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in0_vld,
    output logic              in0_rdy,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [ID_W-1:0]   in0_src_id,
    input  logic [ID_W-1:0]   in0_tgt_id,

    input  logic              in1_vld,
    output logic              in1_rdy,
    input  logic [DATA_W-1:0] in1_data,
    input  logic [ID_W-1:0]   in1_src_id,
    input  logic [ID_W-1:0]   in1_tgt_id,

    output logic              out0_vld,
    input  logic              out0_rdy,
    output logic [DATA_W-1:0] out0_data,
    output logic [ID_W-1:0]   out0_src_id,
    output logic [ID_W-1:0]   out0_tgt_id
);

    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_data;
    logic [ID_W-1:0]   r_out_src_id;
    logic [ID_W-1:0]   r_out_tgt_id;
    logic              r_prio;

    logic              w_load;
    logic              w_any_vld;
    logic              w_gnt;

    assign w_load    = !r_out_vld || out0_rdy;
    assign w_any_vld = in0_vld || in1_vld;

    // On a tie the priority pointer decides; otherwise the lone requester wins.
    always_comb begin
        w_gnt = 1'b0;
        if (in0_vld && in1_vld) begin
            w_gnt = r_prio;
        end else if (in1_vld) begin
            w_gnt = 1'b1;
        end
    end

    // Ready is held low while in reset so no source sees a phantom accept.
    assign in0_rdy = !rst && w_load && w_any_vld && !w_gnt;
    assign in1_rdy = !rst && w_load && w_any_vld &&  w_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld    <= 1'b0;
            r_out_data   <= '0;
            r_out_src_id <= '0;
            r_out_tgt_id <= '0;
            r_prio       <= 1'b0;
        end else if (w_load) begin
            if (w_any_vld) begin
                r_out_vld    <= 1'b1;
                r_out_data   <= w_gnt ? in1_data   : in0_data;
                r_out_src_id <= w_gnt ? in1_src_id : in0_src_id;
                r_out_tgt_id <= w_gnt ? in1_tgt_id : in0_tgt_id;
                r_prio       <= ~w_gnt;
            end else begin
                r_out_vld    <= 1'b0;
            end
        end
    end

    assign out0_vld    = r_out_vld;
    assign out0_data   = r_out_data;
    assign out0_src_id = r_out_src_id;
    assign out0_tgt_id = r_out_tgt_id;

endmodule
`default_nettype wire

// File: tb/tb_toy_bus_rsp_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_toy_bus_rsp_arb_2to1
// Description : Directed bench with a cycle-level reference model for the
//               2:1 response arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toy_bus_rsp_arb_2to1;

    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in0_vld, in0_rdy, in1_vld, in1_rdy;
    logic [DATA_W-1:0] in0_data, in1_data;
    logic [ID_W-1:0]   in0_src_id, in0_tgt_id, in1_src_id, in1_tgt_id;
    logic              out0_vld, out0_rdy;
    logic [DATA_W-1:0] out0_data;
    logic [ID_W-1:0]   out0_src_id, out0_tgt_id;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    toy_bus_rsp_arb_2to1 #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in0_vld    (in0_vld),
        .in0_rdy    (in0_rdy),
        .in0_data   (in0_data),
        .in0_src_id (in0_src_id),
        .in0_tgt_id (in0_tgt_id),
        .in1_vld    (in1_vld),
        .in1_rdy    (in1_rdy),
        .in1_data   (in1_data),
        .in1_src_id (in1_src_id),
        .in1_tgt_id (in1_tgt_id),
        .out0_vld   (out0_vld),
        .out0_rdy   (out0_rdy),
        .out0_data  (out0_data),
        .out0_src_id(out0_src_id),
        .out0_tgt_id(out0_tgt_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the output slot as a one-deep buffer plus a
    // "whose turn on a tie" flag.
    logic              m_init = 1'b0;
    logic              m_vld;
    logic [DATA_W-1:0] m_data;
    logic [ID_W-1:0]   m_src, m_tgt;
    int                m_turn;

    function automatic int winner();
        if (in0_vld && in1_vld) return m_turn;
        if (in0_vld)            return 0;
        if (in1_vld)            return 1;
        return -1;
    endfunction

    function automatic logic slot_free();
        return !m_vld || out0_rdy;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init <= 1'b1;
            m_vld  <= 1'b0;
            m_data <= '0;
            m_src  <= '0;
            m_tgt  <= '0;
            m_turn <= 0;
        end else if (m_init && slot_free()) begin
            case (winner())
                0: begin
                    m_vld <= 1'b1; m_data <= in0_data; m_src <= in0_src_id;
                    m_tgt <= in0_tgt_id; m_turn <= 1;
                end
                1: begin
                    m_vld <= 1'b1; m_data <= in1_data; m_src <= in1_src_id;
                    m_tgt <= in1_tgt_id; m_turn <= 0;
                end
                default: m_vld <= 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_out_vld", {31'b0, out0_vld}, {31'b0, m_vld});
            chk("model_out_data", out0_data, m_data);
            chk("model_out_src", {28'b0, out0_src_id}, {28'b0, m_src});
            chk("model_out_tgt", {28'b0, out0_tgt_id}, {28'b0, m_tgt});
            chk("model_in0_rdy", {31'b0, in0_rdy},
                {31'b0, !rst && slot_free() && winner() == 0});
            chk("model_in1_rdy", {31'b0, in1_rdy},
                {31'b0, !rst && slot_free() && winner() == 1});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rr_exp [6];
    int n0, n1;
    logic a0, a1;

    initial begin
        rr_exp[0] = 32'h100; rr_exp[1] = 32'h200; rr_exp[2] = 32'h101;
        rr_exp[3] = 32'h201; rr_exp[4] = 32'h102; rr_exp[5] = 32'h202;

        // Reset with both inputs valid
        rst = 1'b1; out0_rdy = 1'b1;
        in0_vld = 1'b1; in0_data = 32'hA0; in0_src_id = 4'd1; in0_tgt_id = 4'd2;
        in1_vld = 1'b1; in1_data = 32'hB0; in1_src_id = 4'd3; in1_tgt_id = 4'd4;
        cyc(); cyc();
        #2;
        chk("rst_out_vld", {31'b0, out0_vld}, 32'd0);
        chk("rst_out_data", out0_data, 32'd0);
        chk("rst_out_src", {28'b0, out0_src_id}, 32'd0);
        chk("rst_in0_rdy", {31'b0, in0_rdy}, 32'd0);
        chk("rst_in1_rdy", {31'b0, in1_rdy}, 32'd0);

        // First grant after release goes to port 0
        rst = 1'b0;
        #1;
        chk("first_in0_rdy", {31'b0, in0_rdy}, 32'd1);
        chk("first_in1_rdy", {31'b0, in1_rdy}, 32'd0);
        cyc();
        in0_vld = 1'b0; in1_vld = 1'b0;
        #1;
        chk("first_out_data", out0_data, 32'hA0);
        chk("first_out_vld", {31'b0, out0_vld}, 32'd1);
        cyc();
        chk("drain_out_vld", {31'b0, out0_vld}, 32'd0);

        // Single port 1
        in1_vld = 1'b1; in1_data = 32'hDEAD_BEEF; in1_src_id = 4'd3; in1_tgt_id = 4'd1;
        #1;
        chk("single_in1_rdy", {31'b0, in1_rdy}, 32'd1);
        chk("single_in0_rdy", {31'b0, in0_rdy}, 32'd0);
        cyc();
        in1_vld = 1'b0;
        #1;
        chk("single_out_vld", {31'b0, out0_vld}, 32'd1);
        chk("single_out_data", out0_data, 32'hDEAD_BEEF);
        chk("single_out_src", {28'b0, out0_src_id}, 32'd3);
        chk("single_out_tgt", {28'b0, out0_tgt_id}, 32'd1);

        // Tie round-robin, one beat per cycle
        n0 = 0; n1 = 0;
        for (int k = 0; k < 6; k++) begin
            in0_vld = 1'b1; in0_data = 32'h100 + 32'(n0);
            in1_vld = 1'b1; in1_data = 32'h200 + 32'(n1);
            #2;
            a0 = in0_rdy; a1 = in1_rdy;
            cyc();
            if (a0) n0++;
            if (a1) n1++;
            chk("rr_out_vld", {31'b0, out0_vld}, 32'd1);
            chk("rr_out_data", out0_data, rr_exp[k]);
        end
        in0_data = 32'h100 + 32'(n0);
        in1_data = 32'h200 + 32'(n1);

        // Backpressure: hold for 5 cycles
        out0_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("bp_in0_rdy", {31'b0, in0_rdy}, 32'd0);
            chk("bp_in1_rdy", {31'b0, in1_rdy}, 32'd0);
            chk("bp_out_data", out0_data, 32'h202);
            cyc();
        end
        out0_rdy = 1'b1;
        #1;
        chk("bp_release_in0_rdy", {31'b0, in0_rdy}, 32'd1);
        cyc();
        chk("bp_release_data", out0_data, 32'h103);
        in0_vld = 1'b0; in1_vld = 1'b0;
        cyc();
        chk("bp_drain_vld", {31'b0, out0_vld}, 32'd0);

        // Mid-stall reset
        in0_vld = 1'b1; in0_data = 32'h55; in0_src_id = 4'd5; in0_tgt_id = 4'd6;
        cyc();
        out0_rdy = 1'b0; in0_vld = 1'b0; in1_vld = 1'b1;
        #1;
        chk("stall_out_data", out0_data, 32'h55);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_out_vld", {31'b0, out0_vld}, 32'd0);
        chk("mrst_out_data", out0_data, 32'd0);
        chk("mrst_out_tgt", {28'b0, out0_tgt_id}, 32'd0);
        in0_vld = 1'b1; out0_rdy = 1'b1;
        #1;
        chk("mrst_prio_in0_rdy", {31'b0, in0_rdy}, 32'd1);
        cyc();
        in0_vld = 1'b0; in1_vld = 1'b0;
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
